// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight stream: header field layout and loader FSM encoding.
// Also intended for the stream source/packer that builds these packets.
package weight_loader_pkg;

  localparam int unsigned LAYER_MSB  = 31;
  localparam int unsigned LAYER_LSB  = 24;
  localparam int unsigned NEURON_MSB = 23;
  localparam int unsigned NEURON_LSB = 16;
  localparam int unsigned COUNT_MSB  = 15;
  localparam int unsigned COUNT_LSB  = 0;

  localparam int unsigned LAYER_W  = LAYER_MSB - LAYER_LSB + 1;
  localparam int unsigned NEURON_W = NEURON_MSB - NEURON_LSB + 1;
  localparam int unsigned COUNT_W  = COUNT_MSB - COUNT_LSB + 1;

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SKIP   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/weight_loader.sv
// Parses weight packets from the host stream and writes each weight word into
// the selected neuron's weight memory at sequential addresses.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned numWeight    = 784,
  parameter int unsigned numNeurons   = 30,
  parameter int unsigned layerNo      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [numNeurons-1:0]   w_en,
  output logic [addressWidth-1:0] w_addr,
  output logic [dataWidth-1:0]    w_data,
  output logic                    done,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned NEURON_IDX_W = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [LAYER_W-1:0]  LAYER_ID     = LAYER_W'(layerNo);
  localparam logic [NEURON_W-1:0] NEURON_LIMIT = NEURON_W'(numNeurons);
  localparam logic [COUNT_W-1:0]  COUNT_LIMIT  = COUNT_W'(numWeight);

  state_e                  state_q;
  logic [NEURON_IDX_W-1:0] neuron_q;
  logic [addressWidth-1:0] cnt_q;
  logic [addressWidth-1:0] cnt_d;
  logic [addressWidth-1:0] last_q;
  logic [numNeurons-1:0]   w_en_q;
  logic [addressWidth-1:0] w_addr_q;
  logic [dataWidth-1:0]    w_data_q;
  logic                    done_q;
  logic                    err_q;
  logic                    busy_q;
  logic                    s_ready_q;

  logic                    beat;
  logic [LAYER_W-1:0]      hdr_layer;
  logic [NEURON_W-1:0]     hdr_neuron;
  logic [COUNT_W-1:0]      hdr_count;
  logic                    hdr_bad;
  logic                    final_beat;

  assign beat       = s_valid & s_ready_q;
  assign hdr_layer  = s_data[LAYER_MSB:LAYER_LSB];
  assign hdr_neuron = s_data[NEURON_MSB:NEURON_LSB];
  assign hdr_count  = s_data[COUNT_MSB:COUNT_LSB];
  assign hdr_bad    = (hdr_count == '0) || (hdr_count > COUNT_LIMIT) ||
                      (hdr_neuron >= NEURON_LIMIT);
  assign final_beat = (cnt_q == last_q);
  assign cnt_d      = cnt_q + addressWidth'(1);

  // Packet FSM; write strobes and status pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HEADER;
      neuron_q  <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      w_en_q    <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      s_ready_q <= 1'b1;
      w_en_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      if (beat) begin
        case (state_q)
          ST_HEADER: begin
            if (hdr_layer != LAYER_ID) begin
              if (!s_last) begin
                state_q <= ST_SKIP;
                busy_q  <= 1'b1;
              end
            end else if (hdr_bad) begin
              err_q <= 1'b1;
              if (!s_last) begin
                state_q <= ST_DRAIN;
                busy_q  <= 1'b1;
              end
            end else if (s_last) begin
              err_q <= 1'b1;
            end else begin
              neuron_q <= NEURON_IDX_W'(hdr_neuron);
              last_q   <= addressWidth'(hdr_count - COUNT_W'(1));
              cnt_q    <= '0;
              state_q  <= ST_LOAD;
              busy_q   <= 1'b1;
            end
          end
          ST_LOAD: begin
            w_en_q   <= numNeurons'(1) << neuron_q;
            w_addr_q <= cnt_q;
            w_data_q <= s_data[dataWidth-1:0];
            cnt_q    <= cnt_d;
            if (final_beat && s_last) begin
              done_q  <= 1'b1;
              state_q <= ST_HEADER;
              busy_q  <= 1'b0;
            end else if (final_beat) begin
              err_q   <= 1'b1;
              state_q <= ST_DRAIN;
            end else if (s_last) begin
              err_q   <= 1'b1;
              state_q <= ST_HEADER;
              busy_q  <= 1'b0;
            end
          end
          ST_SKIP, ST_DRAIN: begin
            if (s_last) begin
              state_q <= ST_HEADER;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_HEADER;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_ready = s_ready_q;
  assign w_en    = w_en_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: doc/weight_loader.md
# weight_loader

Stream-to-memory writer that fills the per-neuron weight RAMs of one layer when the design is built without pretrained weights. Sits between the host/DMA weight stream and the write ports (`wen`, `waddr`, `win`) of every weight memory in its layer. It parses a header per packet, one-hot selects the target neuron's memory, and issues one write per weight word with sequential addresses. It reports completion and malformed packets.

## Interface
- `dataWidth`, 16: weight width; equals weight memory data width.
- `addressWidth`, 10: weight memory address width.
- `numWeight`, 784: max weights per neuron in this layer.
- `numNeurons`, 30: neurons (weight memories) in this layer.
- `layerNo`, 1: layer this instance serves.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in 32: stream word.
- `s_valid` in 1: `s_data` valid.
- `s_last` in 1: last word of packet.
- `s_ready` out 1: loader accepts word.
- `w_en` out numNeurons: one-hot write enable; bit n drives `wen` of neuron n.
- `w_addr` out addressWidth: shared write address.
- `w_data` out dataWidth: shared write data.
- `done` out 1: one-cycle pulse, packet loaded correctly.
- `err` out 1: one-cycle pulse, packet malformed.
- `busy` out 1: high while not in HEADER.

## Operation
- A beat is accepted when `s_valid & s_ready`. `s_ready` is 0 while `rst` is high and 1 otherwise. The loader never stalls because memory writes are single-cycle.
- Packet format:
  - Header word: [31:24] layer, [23:16] neuron, [15:0] count.
  - Followed by count weight words. Weight is `s_data[dataWidth-1:0]`; upper bits are ignored.
- FSM states: HEADER, LOAD, SKIP, DRAIN. Reset state is HEADER.
- HEADER:
  - If layer ≠ `layerNo`: go to SKIP; if the header itself has `s_last`, stay in HEADER. No `err`, no writes.
  - Else if count == 0, count > `numWeight`, or neuron ≥ `numNeurons`: pulse `err`; go to DRAIN, or stay in HEADER if `s_last`.
  - Else if `s_last`: pulse `err`, stay in HEADER.
  - Else: latch the neuron and count, clear the address counter, go to LOAD.
- LOAD, each accepted beat:
  - Write `w_data`=weight at `w_addr`=counter with `w_en`=one-hot(neuron), then increment the counter.
  - The beat where the counter equals count-1 is final.
  - Final beat with `s_last`: pulse `done`, go to HEADER.
  - Final beat without `s_last`: pulse `err`, go to DRAIN.
  - Non-final beat with `s_last`: the write still happens; pulse `err`, go to HEADER.
- SKIP: discard beats until `s_last`, then go to HEADER.
- DRAIN: discard beats until `s_last`, then go to HEADER.
- Address counter width is addressWidth. Counter never exceeds `numWeight`-1, so there is no wrap.

## Timing
- Reset values: `w_en`=0, `w_addr`=0, `w_data`=0, `done`=0, `err`=0, `busy`=0, `s_ready`=0. All outputs are registered.
- Beat accepted in cycle N → `w_en`/`w_addr`/`w_data` valid in cycle N+1 for exactly one cycle. `w_addr`/`w_data` hold their value when `w_en`=0.
- `done`/`err` pulse in cycle N+1 of the triggering beat, coincident with the final write where one occurs.
- Back-to-back beats sustain one write per cycle. A new header may directly follow a final weight with no gap cycle.
- `rst` mid-packet: FSM returns to HEADER; any write registered for the next cycle is cancelled (`w_en`=0). Memory contents already written are kept.
- `s_valid`=0 cycles inside a packet: no write, state and counter hold.

## Structure
- Shared package: header field positions (LAYER_MSB/LSB, NEURON_MSB/LSB, COUNT_MSB/LSB) and FSM state encoding. The future stream source/packer uses the same package.
- Single module. No sub-module is warranted; one-hot decode is inline.
- Integration: `w_en[n]`→`wen`, `w_addr`→`waddr`, `w_data`→`win` of neuron n's weight memory, built with pretrained undefined.

## Test plan
- Header layer=1, neuron=3, count=4, weights 0x0011..0x0014, `s_last` on the 4th → `w_en`=0b1000 writes at addr 0..3 with data 0x0011..0x0014, `done` once, read-back matches.
- Header layer=2 (instance `layerNo`=1) plus 5 words → no `w_en`, no `err`. The next valid packet loads normally.
- Count=785 with `numWeight`=784; then separately neuron=30 → `err` one cycle after each header, following words dropped until `s_last`.
- Count=4 but `s_last` on the 2nd weight → 2 writes at addr 0,1, `err` with the 2nd write, next header accepted.
- Count=3, `s_valid` toggling every other cycle → exactly 3 writes at addr 0..2, `done` with the last write.
- `rst` asserted after 2 of 4 weights → no further writes, all outputs 0 next cycle; a fresh packet then loads from addr 0.
